// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Holds the state encoding, status counter widths and parameter defaults.
package pll_seq_pkg;

   localparam int unsigned DefRstHoldCyc     = 16;
   localparam int unsigned DefLockTimeoutCyc = 50000;
   localparam int unsigned DefLockStableCyc  = 1024;
   localparam int unsigned DefMaxRetry       = 3;

   localparam int unsigned RetryCntW = 2;
   localparam int unsigned LolCntW   = 8;

   typedef enum logic [2:0] {
      StPllRst,
      StWaitLock,
      StStable,
      StRun,
      StFault
   } seq_state_e;

   // Bits needed for a counter running 0 .. n-1 (never narrower than 1).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and status signals of the lock sequencer.
// master: the sequencer; slave: the PLL and the system it resets.
interface pll_lock_sequencer_if;
   import pll_seq_pkg::*;

   logic                 pll_locked;
   logic                 relock_req;
   logic                 pll_rst;
   logic                 sys_rst_n;
   logic                 ready;
   logic                 error;
   logic [RetryCntW-1:0] retry_cnt;
   logic [LolCntW-1:0]   lol_cnt;

   modport master (
      input  pll_locked,
      input  relock_req,
      output pll_rst,
      output sys_rst_n,
      output ready,
      output error,
      output retry_cnt,
      output lol_cnt
   );

   modport slave (
      output pll_locked,
      output relock_req,
      input  pll_rst,
      input  sys_rst_n,
      input  ready,
      input  error,
      input  retry_cnt,
      input  lol_cnt
   );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
// Both flops clear on reset so a stale lock cannot leak into a new sequence.
module pll_lock_sync (
   input  logic clk_i,
   input  logic rst_n,
   input  logic locked_i,
   output logic locked_o
);

   logic [1:0] sync_d;
   logic [1:0] sync_q;

   always_comb begin
      sync_d = {sync_q[0], locked_i};
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign locked_o = sync_q[1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock qualification and system reset release, retrying
// timed-out attempts and parking in a fault state once retries are spent.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYC     = DefRstHoldCyc,
   parameter int unsigned LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
   parameter int unsigned LOCK_STABLE_CYC  = DefLockStableCyc,
   parameter int unsigned MAX_RETRY        = DefMaxRetry
) (
   input  logic                 refclk,
   input  logic                 rst_n,
   pll_lock_sequencer_if.master seq_if
);

   localparam int unsigned HoldW = cnt_width(RST_HOLD_CYC);
   localparam int unsigned ToW   = cnt_width(LOCK_TIMEOUT_CYC);
   localparam int unsigned StabW = cnt_width(LOCK_STABLE_CYC);

   localparam logic [HoldW-1:0]     HoldLast  = HoldW'(RST_HOLD_CYC - 1);
   localparam logic [ToW-1:0]       ToLast    = ToW'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [StabW-1:0]     StabLast  = StabW'(LOCK_STABLE_CYC - 1);
   localparam logic [RetryCntW-1:0] MaxRetryV = RetryCntW'(MAX_RETRY);
   localparam logic [LolCntW-1:0]   LolMax    = '1;

   seq_state_e           state_d, state_q;
   logic [HoldW-1:0]     hold_cnt_d, hold_cnt_q;
   logic [ToW-1:0]       to_cnt_d, to_cnt_q;
   logic [StabW-1:0]     stab_cnt_d, stab_cnt_q;
   logic [RetryCntW-1:0] retry_cnt_d, retry_cnt_q;
   logic [LolCntW-1:0]   lol_cnt_d, lol_cnt_q;
   logic                 pll_rst_d, pll_rst_q;
   logic                 sys_rst_n_d, sys_rst_n_q;
   logic                 ready_d, ready_q;
   logic                 error_d, error_q;

   logic                 locked_s;
   logic                 timeout;
   logic                 go_rst;
   logic                 go_timeout;

   pll_lock_sync u_lock_sync (
      .clk_i    (refclk),
      .rst_n    (rst_n),
      .locked_i (seq_if.pll_locked),
      .locked_o (locked_s)
   );

   assign timeout = (to_cnt_q == ToLast);

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      to_cnt_d    = to_cnt_q;
      stab_cnt_d  = stab_cnt_q;
      retry_cnt_d = retry_cnt_q;
      lol_cnt_d   = lol_cnt_q;
      go_rst      = 1'b0;
      go_timeout  = 1'b0;

      // A lock loss in RUN is still counted when a relock arrives with it.
      if (state_q == StRun && !locked_s && lol_cnt_q != LolMax) begin
         lol_cnt_d = lol_cnt_q + LolCntW'(1);
      end

      if (seq_if.relock_req) begin
         go_rst      = 1'b1;
         retry_cnt_d = '0;
      end else begin
         unique case (state_q)
            StPllRst: begin
               if (hold_cnt_q == HoldLast) begin
                  state_d = StWaitLock;
               end else begin
                  hold_cnt_d = hold_cnt_q + HoldW'(1);
               end
            end
            StWaitLock: begin
               to_cnt_d = to_cnt_q + ToW'(1);
               if (timeout) begin
                  go_timeout = 1'b1;
               end else if (locked_s) begin
                  state_d    = StStable;
                  stab_cnt_d = '0;
               end
            end
            StStable: begin
               // Timeout keeps running here so a chattering lock still retries.
               to_cnt_d = to_cnt_q + ToW'(1);
               if (locked_s && stab_cnt_q == StabLast) begin
                  state_d     = StRun;
                  retry_cnt_d = '0;
               end else if (timeout) begin
                  go_timeout = 1'b1;
               end else if (!locked_s) begin
                  state_d = StWaitLock;
               end else begin
                  stab_cnt_d = stab_cnt_q + StabW'(1);
               end
            end
            StRun: begin
               if (!locked_s) begin
                  go_rst      = 1'b1;
                  retry_cnt_d = '0;
               end
            end
            StFault: begin
               state_d = StFault;
            end
            default: begin
               go_rst = 1'b1;
            end
         endcase
      end

      if (go_timeout) begin
         if (retry_cnt_q < MaxRetryV) begin
            retry_cnt_d = retry_cnt_q + RetryCntW'(1);
            go_rst      = 1'b1;
         end else begin
            state_d = StFault;
         end
      end

      if (go_rst) begin
         state_d    = StPllRst;
         hold_cnt_d = '0;
         to_cnt_d   = '0;
      end

      // Outputs decode the next state so the registered copies track state_q.
      pll_rst_d   = (state_d == StPllRst) || (state_d == StFault);
      sys_rst_n_d = (state_d == StRun);
      ready_d     = (state_d == StRun);
      error_d     = (state_d == StFault);
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StPllRst;
         hold_cnt_q  <= '0;
         to_cnt_q    <= '0;
         stab_cnt_q  <= '0;
         retry_cnt_q <= '0;
         lol_cnt_q   <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         to_cnt_q    <= to_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         lol_cnt_q   <= lol_cnt_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
      end
   end

   assign seq_if.pll_rst   = pll_rst_q;
   assign seq_if.sys_rst_n = sys_rst_n_q;
   assign seq_if.ready     = ready_q;
   assign seq_if.error     = error_q;
   assign seq_if.retry_cnt = retry_cnt_q;
   assign seq_if.lol_cnt   = lol_cnt_q;

endmodule
